// File: rtl/cdc_arb_pkg.sv
// Shared types and helpers for the CDC FIFO write-port arbiter.
// Holds the arbiter state encoding, the ID-width helper and the stall counter width.
package cdc_arb_pkg;

  typedef enum logic {IDLE, BURST} arb_state_e;

  // Wide enough for any TIMEOUT up to 255
  localparam int STALL_W = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cdc_fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: the first asserted request after last_grant wins,
// wrapping modulo NCH. It holds no state, so it can be reused by other shared ports.
module rr_pick
  import cdc_arb_pkg::*;
#(
  parameter int NCH = 4,
  parameter int IDW = clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IDW-1:0] last_grant,
  output logic [IDW-1:0] winner,
  output logic           any_req
);

  logic [IDW-1:0] idx;

  // Scan from lowest to highest priority so the highest-priority hit is assigned last.
  always_comb begin
    winner  = '0;
    idx     = '0;
    any_req = |req;
    for (int i = NCH; i >= 1; i--) begin
      idx = IDW'((int'(last_grant) + i) % NCH);
      if (req[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/cdc_fifo_wr_arbiter.sv
// Record-granular round-robin arbiter for the wclk write port of a CDC FIFO.
// Each word is tagged with its channel ID. A per-owner stall timeout frees the port.
module cdc_fifo_wr_arbiter
  import cdc_arb_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255,
  localparam int IDW    = clog2(NCH)
) (
  input  logic              wclk,
  input  logic              rrst,
  input  logic [NCH-1:0]    req_valid,
  input  logic [NCH*DW-1:0] req_data,
  input  logic [NCH-1:0]    req_last,
  output logic [NCH-1:0]    req_ready,
  output logic [DW+IDW-1:0] fifo_wdata,
  output logic              fifo_winc,
  input  logic              fifo_wfull,
  output logic [IDW-1:0]    grant_id,
  output logic              busy,
  output logic [NCH-1:0]    timeout_err,
  input  logic              clr_err,
  output logic [31:0]       word_cnt
);

  arb_state_e         state, state_nxt;
  logic [IDW-1:0]     last_grant;
  logic [IDW-1:0]     winner;
  logic               any_req;
  logic [STALL_W-1:0] stall_cnt;
  logic [NCH-1:0]     err_set;
  logic               release_grant;

  rr_pick #(.NCH(NCH), .IDW(IDW)) u_pick (
    .req       (req_valid),
    .last_grant(last_grant),
    .winner    (winner),
    .any_req   (any_req)
  );

  assign fifo_wdata = {grant_id, req_data[grant_id*DW +: DW]};
  assign busy       = (state == BURST) & ~rrst;

  // Outputs are gated by rrst so a word in flight is never written during reset.
  always_comb begin
    req_ready     = '0;
    fifo_winc     = 1'b0;
    err_set       = '0;
    release_grant = 1'b0;
    state_nxt     = state;
    if (state == BURST) begin
      if (!rrst) begin
        req_ready[grant_id] = ~fifo_wfull;
        fifo_winc           = req_valid[grant_id] & ~fifo_wfull;
      end
      if (fifo_winc && req_last[grant_id]) begin
        release_grant = 1'b1;
      end else if (!req_valid[grant_id] && stall_cnt == STALL_W'(TIMEOUT - 1)) begin
        release_grant     = 1'b1;
        err_set[grant_id] = 1'b1;
      end
      if (release_grant) state_nxt = IDLE;
    end else if (any_req) begin
      state_nxt = BURST;
    end
  end

  always_ff @(posedge wclk) begin
    if (rrst) begin
      state       <= IDLE;
      grant_id    <= '0;
      last_grant  <= IDW'(NCH - 1);
      stall_cnt   <= '0;
      timeout_err <= '0;
      word_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      timeout_err <= (timeout_err & ~{NCH{clr_err}}) | err_set;
      if (fifo_winc) word_cnt <= word_cnt + 32'd1;
      if (state == IDLE) begin
        if (any_req) begin
          grant_id  <= winner;
          stall_cnt <= '0;
        end
      end else begin
        if (release_grant) last_grant <= grant_id;
        // Backpressure with valid high leaves the counter untouched
        if (fifo_winc || release_grant) stall_cnt <= '0;
        else if (!req_valid[grant_id])  stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cdc_fifo_wr_arbiter.sv
// Self-checking bench for cdc_fifo_wr_arbiter: directed scenarios then random traffic,
// compared every cycle against a transaction-level model of owner, counters and flags.
module tb_cdc_fifo_wr_arbiter;

  localparam int NCH     = 4;
  localparam int DW      = 32;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 255;

  logic              wclk = 1'b0;
  logic              rrst;
  logic [NCH-1:0]    req_valid;
  logic [NCH*DW-1:0] req_data;
  logic [NCH-1:0]    req_last;
  logic [NCH-1:0]    req_ready;
  logic [DW+IDW-1:0] fifo_wdata;
  logic              fifo_winc;
  logic              fifo_wfull;
  logic [IDW-1:0]    grant_id;
  logic              busy;
  logic [NCH-1:0]    timeout_err;
  logic              clr_err;
  logic [31:0]       word_cnt;

  always #5 wclk = ~wclk;

  cdc_fifo_wr_arbiter #(.NCH(NCH), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .wclk       (wclk),
    .rrst       (rrst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_wdata (fifo_wdata),
    .fifo_winc  (fifo_winc),
    .fifo_wfull (fifo_wfull),
    .grant_id   (grant_id),
    .busy       (busy),
    .timeout_err(timeout_err),
    .clr_err    (clr_err),
    .word_cnt   (word_cnt)
  );

  int checkCount = 0;
  int failCount  = 0;

  // Source side: words left in each channel's current record and its present word
  int          recLeft[NCH];
  int          autoLen[NCH];
  bit          pause[NCH];
  logic [DW-1:0] curData[NCH];
  bit          randomMode, wfullHold, rstReq, clrReq;

  // Reference model: owner is -1 while nobody holds the port
  int          mOwner, mGrant, mLast, mStall;
  logic [NCH-1:0] mErr;
  logic [31:0] mCnt;
  bit          mKnown;
  logic [NCH-1:0] expReady;
  bit          expWinc, expBusy;
  int          grantLog[$];

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    assert (got === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic startRecord(input int c, input int len);
    recLeft[c] = len;
    curData[c] = $urandom;
  endtask

  task automatic computeExpected();
    expReady = '0;
    expWinc  = 1'b0;
    expBusy  = 1'b0;
    if (!rrst && mOwner >= 0) begin
      expBusy          = 1'b1;
      expReady[mOwner] = !fifo_wfull;
      expWinc          = req_valid[mOwner] && !fifo_wfull;
    end
  endtask

  task automatic checkOutput();
    logic [DW+IDW-1:0] expData;
    logic [IDW-1:0]    g;
    if (!mKnown) return;
    g       = mGrant[IDW-1:0];
    expData = {g, curData[mGrant]};
    checkVal("req_ready",   64'(req_ready),   64'(expReady));
    checkVal("fifo_winc",   64'(fifo_winc),   64'(expWinc));
    checkVal("busy",        64'(busy),        64'(expBusy));
    checkVal("grant_id",    64'(grant_id),    64'(g));
    checkVal("fifo_wdata",  64'(fifo_wdata),  64'(expData));
    checkVal("timeout_err", 64'(timeout_err), 64'(mErr));
    checkVal("word_cnt",    64'(word_cnt),    64'(mCnt));
  endtask

  task automatic modelStep();
    logic [NCH-1:0] setE;
    bit found;
    int c;
    if (rrst) begin
      mOwner = -1; mGrant = 0; mLast = NCH - 1; mStall = 0;
      mErr = '0; mCnt = '0; mKnown = 1'b1;
      return;
    end
    setE  = '0;
    found = 1'b0;
    if (mOwner < 0) begin
      for (int i = 1; i <= NCH; i++) begin
        c = (mLast + i) % NCH;
        if (!found && req_valid[c]) begin
          found = 1'b1; mOwner = c; mGrant = c; mStall = 0;
        end
      end
    end else if (expWinc) begin
      c = mOwner;
      grantLog.push_back(c);
      mCnt   = mCnt + 32'd1;
      mStall = 0;
      if (req_last[c]) begin mLast = c; mOwner = -1; end
      recLeft[c] = recLeft[c] - 1;
      curData[c] = $urandom;
      if (recLeft[c] == 0 && autoLen[c] > 0) startRecord(c, autoLen[c]);
      if (randomMode && $urandom_range(0, 7) == 0) pause[c] = 1'b1;
    end else if (!req_valid[mOwner]) begin
      mStall++;
      if (mStall == TIMEOUT) begin
        setE[mOwner] = 1'b1; mLast = mOwner; mOwner = -1; mStall = 0;
      end
    end
    mErr = (clr_err ? '0 : mErr) | setE;
  endtask

  // One cycle: drive at the falling edge, check, then advance the model
  task automatic applyStimulus();
    @(negedge wclk);
    if (randomMode) begin
      wfullHold = ($urandom_range(0, 3) == 0);
      clrReq    = ($urandom_range(0, 31) == 0);
      for (int c = 0; c < NCH; c++) begin
        if (recLeft[c] == 0 && $urandom_range(0, 3) == 0) startRecord(c, $urandom_range(1, 4));
        if (pause[c] && $urandom_range(0, 3) == 0) pause[c] = 1'b0;
      end
    end
    rrst       = rstReq;
    clr_err    = clrReq;
    fifo_wfull = wfullHold;
    for (int c = 0; c < NCH; c++) begin
      req_valid[c]           = (recLeft[c] > 0) && !pause[c];
      req_last[c]            = (recLeft[c] == 1);
      req_data[c*DW +: DW]   = curData[c];
    end
    #1;
    computeExpected();
    checkOutput();
    modelStep();
  endtask

  task automatic waitEdge();
    @(posedge wclk);
    #1;
  endtask

  int exp1[6] = '{0, 0, 0, 2, 2, 2};

  initial begin
    for (int c = 0; c < NCH; c++) begin
      recLeft[c] = 0; autoLen[c] = 0; pause[c] = 1'b0; curData[c] = '0;
    end
    randomMode = 1'b0; wfullHold = 1'b0; clrReq = 1'b0; rstReq = 1'b1;
    mKnown = 1'b0; mOwner = -1; mGrant = 0; mLast = NCH - 1; mStall = 0;
    mErr = '0; mCnt = '0;
    rrst = 1'b1; clr_err = 1'b0; fifo_wfull = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0;

    $display("[TB] reset and two 3-word records on ch0 and ch2");
    repeat (2) applyStimulus();
    checkVal("rst_word_cnt", 64'(word_cnt), 64'd0);
    checkVal("rst_grant", 64'(grant_id), 64'd0);
    rstReq = 1'b0;
    startRecord(0, 3);
    startRecord(2, 3);
    grantLog.delete();
    repeat (10) applyStimulus();
    checkVal("t1_word_cnt", 64'(word_cnt), 64'd6);
    checkVal("t1_count", 64'(grantLog.size()), 64'd6);
    for (int i = 0; i < 6; i++) checkVal("t1_order", 64'(grantLog[i]), 64'(exp1[i]));

    $display("[TB] all channels streaming 1-word records");
    rstReq = 1'b1;
    for (int c = 0; c < NCH; c++) begin autoLen[c] = 1; startRecord(c, 1); end
    applyStimulus();
    rstReq = 1'b0;
    grantLog.delete();
    repeat (16) applyStimulus();
    checkVal("t2_count", 64'(grantLog.size()), 64'd8);
    for (int i = 0; i < 8; i++) checkVal("t2_order", 64'(grantLog[i]), 64'(i % NCH));
    for (int c = 0; c < NCH; c++) autoLen[c] = 0;
    repeat (12) applyStimulus();

    $display("[TB] long backpressure mid-record");
    grantLog.delete();
    startRecord(1, 4);
    repeat (2) applyStimulus();
    wfullHold = 1'b1;
    repeat (300) applyStimulus();
    checkVal("t3_no_err", 64'(timeout_err), 64'd0);
    wfullHold = 1'b0;
    repeat (6) applyStimulus();
    checkVal("t3_words", 64'(grantLog.size()), 64'd4);

    $display("[TB] stalled owner times out");
    startRecord(1, 4);
    repeat (2) applyStimulus();
    pause[1] = 1'b1;
    startRecord(2, 2);
    repeat (254) applyStimulus();
    waitEdge();
    checkVal("t4_still_busy", 64'(busy), 64'd1);
    clrReq = 1'b1;
    applyStimulus();
    clrReq = 1'b0;
    waitEdge();
    checkVal("t4_err_set", 64'(timeout_err), 64'b0010);
    clrReq = 1'b1;
    applyStimulus();
    clrReq = 1'b0;
    waitEdge();
    checkVal("t4_err_clr", 64'(timeout_err), 64'd0);
    checkVal("t4_next_grant", 64'(grant_id), 64'd2);
    pause[1] = 1'b0;
    repeat (12) applyStimulus();

    $display("[TB] reset in the middle of a ch3 record");
    startRecord(3, 4);
    repeat (3) applyStimulus();
    startRecord(0, 2);
    rstReq = 1'b1;
    applyStimulus();
    rstReq = 1'b0;
    waitEdge();
    checkVal("t5_word_cnt", 64'(word_cnt), 64'd0);
    grantLog.delete();
    repeat (10) applyStimulus();
    checkVal("t5_first_grant", 64'(grantLog[0]), 64'd0);

    $display("[TB] word counter wrap");
    #2;
    force dut.word_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.word_cnt;
    mCnt = 32'hFFFF_FFFF;
    startRecord(1, 1);
    repeat (4) applyStimulus();
    checkVal("t6_wrap", 64'(word_cnt), 64'd0);

    $display("[TB] random traffic");
    randomMode = 1'b1;
    repeat (2000) applyStimulus();
    randomMode = 1'b0;
    wfullHold  = 1'b0;
    clrReq     = 1'b0;
    for (int c = 0; c < NCH; c++) pause[c] = 1'b0;
    repeat (40) applyStimulus();

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
